throw_sequencer: RTL and testbench



---
 rtl/ball_pkg.sv | 20 ++
 rtl/key_stepper.sv | 79 +++++++
 rtl/throw_sequencer.sv | 142 ++++++++++++++
 tb/tb_throw_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ball_pkg.sv
// rtl/ball_pkg.sv - shared phase encoding, key indices and widths for the ball thrower
package ball_pkg;

    localparam int ANGLE_W = 4;
    localparam int POWER_W = 4;
    localparam int SCORE_W = 8;

    localparam int KEY_ANG_UP = 0;
    localparam int KEY_ANG_DN = 1;
    localparam int KEY_PWR_UP = 2;
    localparam int KEY_PWR_DN = 3;

    // Encoding 2'd3 is deliberately absent; the sequencer recovers from it to AIM.
    typedef enum logic [1:0] {
        AIM    = 2'd0,
        FLIGHT = 2'd1,
        RESULT = 2'd2
    } phase_e;

endpackage

// File: rtl/key_stepper.sv
// rtl/key_stepper.sv - press detection and saturating up/down step for one key pair
// AUTO_REPEAT_EN adds a held-key repeat every REPEAT_FRAMES ticks.
module key_stepper #(
    parameter int W    = 4,
    parameter int MAX  = 8,
    parameter int INIT = 4
`ifdef AUTO_REPEAT_EN
    ,
    parameter int REPEAT_FRAMES = 8
`endif
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         tick_i,
    input  logic         aim_i,
    input  logic         freeze_i,
    input  logic         up_i,
    input  logic         dn_i,
    output logic [W-1:0] value_o
);

    logic         up_prev_q, dn_prev_q;
    logic [W-1:0] value_q, value_d;
    logic         up_evt, dn_evt, rep_up, rep_dn, step_en;

`ifdef AUTO_REPEAT_EN
    localparam int RW = $clog2(REPEAT_FRAMES + 1);
    logic [RW-1:0] up_cnt_q, dn_cnt_q;

    assign rep_up = tick_i && up_i && up_prev_q && (up_cnt_q == RW'(REPEAT_FRAMES - 1));
    assign rep_dn = tick_i && dn_i && dn_prev_q && (dn_cnt_q == RW'(REPEAT_FRAMES - 1));

    // Counters restart on every fresh press so repeats are phased from the press tick.
    always_ff @(posedge clk_i) begin
        if (rst_i || !aim_i || !up_i)
            up_cnt_q <= '0;
        else if (tick_i)
            up_cnt_q <= (!up_prev_q || rep_up) ? '0 : up_cnt_q + 1'b1;
        if (rst_i || !aim_i || !dn_i)
            dn_cnt_q <= '0;
        else if (tick_i)
            dn_cnt_q <= (!dn_prev_q || rep_dn) ? '0 : dn_cnt_q + 1'b1;
    end
`else
    assign rep_up = 1'b0;
    assign rep_dn = 1'b0;
`endif

    assign up_evt  = (tick_i && up_i && !up_prev_q) || rep_up;
    assign dn_evt  = (tick_i && dn_i && !dn_prev_q) || rep_dn;
    assign step_en = tick_i && aim_i && !freeze_i;

    always_comb begin
        value_d = value_q;
        if (step_en) begin
            if (up_evt && !dn_evt && value_q != W'(MAX))
                value_d = value_q + 1'b1;
            else if (dn_evt && !up_evt && value_q != '0)
                value_d = value_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            up_prev_q <= 1'b0;
            dn_prev_q <= 1'b0;
            value_q   <= W'(INIT);
        end else begin
            if (tick_i) begin
                up_prev_q <= up_i;
                dn_prev_q <= dn_i;
            end
            value_q <= value_d;
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/throw_sequencer.sv
// rtl/throw_sequencer.sv - aim/flight/result game flow, launch pulse and hit score
// AUTO_REPEAT_EN enables held-key auto-repeat in the angle and power steppers.
module throw_sequencer
    import ball_pkg::*;
#(
    parameter int ANGLE_MAX  = 8,
    parameter int POWER_MAX  = 15,
    parameter int ANGLE_INIT = 4,
    parameter int POWER_INIT = 8,
`ifdef AUTO_REPEAT_EN
    parameter int REPEAT_FRAMES = 8,
`endif
    parameter int FLIGHT_TIMEOUT = 600,
    parameter int HOLD_FRAMES    = 120
) (
    input  logic               VGA_CLK,
    input  logic               rst,
    input  logic               update,
    input  logic [3:0]         key_n,
    input  logic               fire,
    input  logic               ball_landed,
    input  logic               ball_hit,
    output logic [ANGLE_W-1:0] angle,
    output logic [POWER_W-1:0] power,
    output logic               launch,
    output logic               arrow_en,
    output logic [1:0]         phase,
    output logic [SCORE_W-1:0] score
);

    localparam int TMAX = (FLIGHT_TIMEOUT > HOLD_FRAMES) ? FLIGHT_TIMEOUT : HOLD_FRAMES;
    localparam int TW   = $clog2(TMAX + 1);

    logic [3:0]         key_s1_q, key_s2_q;
    logic               fire_s1_q, fire_s2_q, fire_prev_q;
    phase_e             phase_q, phase_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic               launch_q, launch_d;
    logic               fire_edge, aim;

    assign fire_edge = update && fire_s2_q && !fire_prev_q;
    assign aim       = (phase_q == AIM);

    always_comb begin
        phase_d  = phase_q;
        timer_d  = timer_q;
        score_d  = score_q;
        launch_d = 1'b0;
        case (phase_q)
            AIM: begin
                if (fire_edge) begin
                    phase_d  = FLIGHT;
                    launch_d = 1'b1;
                    timer_d  = '0;
                end
            end
            FLIGHT: begin
                // A landing beats a timeout that expires on the same cycle.
                if (ball_landed) begin
                    phase_d = RESULT;
                    timer_d = '0;
                    if (ball_hit && score_q != '1)
                        score_d = score_q + 1'b1;
                end else if (update) begin
                    if (timer_q == TW'(FLIGHT_TIMEOUT - 1)) begin
                        phase_d = RESULT;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end
            RESULT: begin
                if (update) begin
                    if (timer_q == TW'(HOLD_FRAMES - 1)) begin
                        phase_d = AIM;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end
            default: begin
                phase_d = AIM;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge VGA_CLK) begin
        if (rst) begin
            key_s1_q    <= '0;
            key_s2_q    <= '0;
            fire_s1_q   <= 1'b0;
            fire_s2_q   <= 1'b0;
            fire_prev_q <= 1'b0;
            phase_q     <= AIM;
            timer_q     <= '0;
            score_q     <= '0;
            launch_q    <= 1'b0;
        end else begin
            key_s1_q  <= ~key_n;
            key_s2_q  <= key_s1_q;
            fire_s1_q <= fire;
            fire_s2_q <= fire_s1_q;
            // Tracks in every phase so a switch left high never relaunches.
            if (update)
                fire_prev_q <= fire_s2_q;
            phase_q  <= phase_d;
            timer_q  <= timer_d;
            score_q  <= score_d;
            launch_q <= launch_d;
        end
    end

    key_stepper #(
        .W(ANGLE_W), .MAX(ANGLE_MAX), .INIT(ANGLE_INIT)
`ifdef AUTO_REPEAT_EN
        , .REPEAT_FRAMES(REPEAT_FRAMES)
`endif
    ) u_angle (
        .clk_i(VGA_CLK), .rst_i(rst), .tick_i(update), .aim_i(aim), .freeze_i(fire_edge),
        .up_i(key_s2_q[KEY_ANG_UP]), .dn_i(key_s2_q[KEY_ANG_DN]), .value_o(angle)
    );

    key_stepper #(
        .W(POWER_W), .MAX(POWER_MAX), .INIT(POWER_INIT)
`ifdef AUTO_REPEAT_EN
        , .REPEAT_FRAMES(REPEAT_FRAMES)
`endif
    ) u_power (
        .clk_i(VGA_CLK), .rst_i(rst), .tick_i(update), .aim_i(aim), .freeze_i(fire_edge),
        .up_i(key_s2_q[KEY_PWR_UP]), .dn_i(key_s2_q[KEY_PWR_DN]), .value_o(power)
    );

    assign launch   = launch_q;
    assign arrow_en = aim;
    assign phase    = phase_q;
    assign score    = score_q;

endmodule

// File: tb/tb_throw_sequencer.sv
// tb/tb_throw_sequencer.sv - self-checking bench for throw_sequencer (AUTO_REPEAT_EN aware)
module tb_throw_sequencer;

    logic       VGA_CLK = 1'b0;
    logic       rst = 1'b1, update = 1'b0, fire = 1'b0, ball_landed = 1'b0, ball_hit = 1'b0;
    logic [3:0] key_n = 4'hF;
    logic [3:0] angle, power;
    logic       launch, arrow_en;
    logic [1:0] phase;
    logic [7:0] score;

    int checks = 0;
    int errors = 0;

`ifdef AUTO_REPEAT_EN
    localparam int REP = 8;
`endif

    throw_sequencer dut (
        .VGA_CLK(VGA_CLK), .rst(rst), .update(update), .key_n(key_n), .fire(fire),
        .ball_landed(ball_landed), .ball_hit(ball_hit), .angle(angle), .power(power),
        .launch(launch), .arrow_en(arrow_en), .phase(phase), .score(score)
    );

    always #5 VGA_CLK = ~VGA_CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    task automatic idle(input int n);
        repeat (n) @(negedge VGA_CLK);
    endtask

    task automatic tick();
        update = 1'b1;
        @(negedge VGA_CLK);
        update = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic press(input int k);
        key_n[k] = 1'b0; idle(3); tick();
        key_n[k] = 1'b1; idle(3); tick();
    endtask

    task automatic fire_toggle();
        fire = 1'b0; idle(3); tick();
        fire = 1'b1; idle(3); tick();
    endtask

    task automatic land(input logic hit);
        ball_landed = 1'b1; ball_hit = hit;
        @(negedge VGA_CLK);
        ball_landed = 1'b0; ball_hit = 1'b0;
    endtask

    task automatic reset_dut();
        rst = 1'b1; key_n = 4'hF; fire = 1'b0; ball_landed = 1'b0; ball_hit = 1'b0; update = 1'b0;
        idle(2);
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_reset();
        reset_dut();
        checks++; if (phase !== 2'd0) begin errors++; $display("FAIL reset_phase got %0d want 0", phase); end
        checks++; if (angle !== 4'd4) begin errors++; $display("FAIL reset_angle got %0d want 4", angle); end
        checks++; if (power !== 4'd8) begin errors++; $display("FAIL reset_power got %0d want 8", power); end
        checks++; if (launch !== 1'b0) begin errors++; $display("FAIL reset_launch got %0d want 0", launch); end
        checks++; if (arrow_en !== 1'b1) begin errors++; $display("FAIL reset_arrow got %0d want 1", arrow_en); end
        checks++; if (score !== 8'd0) begin errors++; $display("FAIL reset_score got %0d want 0", score); end
    endtask

    task automatic test_steps();
        logic [3:0] want;
        repeat (3) press(0);
        checks++; if (angle !== 4'd7) begin errors++; $display("FAIL angle_3up got %0d want 7", angle); end
        repeat (2) press(0);
        checks++; if (angle !== 4'd8) begin errors++; $display("FAIL angle_sat got %0d want 8", angle); end
        key_n[3] = 1'b0; idle(3); ticks(20);
`ifdef AUTO_REPEAT_EN
        want = 4'd5;
`else
        want = 4'd7;
`endif
        checks++; if (power !== want) begin errors++; $display("FAIL power_hold20 got %0d want %0d", power, want); end
        key_n[3] = 1'b1; idle(3); tick();
    endtask

    task automatic test_same_tick();
        reset_dut();
        key_n[1:0] = 2'b00; idle(3); tick();
        checks++; if (angle !== 4'd4) begin errors++; $display("FAIL angle_both got %0d want 4", angle); end
        key_n[1:0] = 2'b11; idle(3); tick();
`ifdef AUTO_REPEAT_EN
        key_n[2] = 1'b0; idle(3); ticks(17);
        checks++; if (power !== 4'd11) begin errors++; $display("FAIL power_repeat17 got %0d want 11", power); end
        key_n[2] = 1'b1; idle(3); tick();
`endif
    endtask

    task automatic test_random_aim();
        int ang, pw;
        logic [3:0] prev, cur, evt;
`ifdef AUTO_REPEAT_EN
        int held [4];
        for (int k = 0; k < 4; k++) held[k] = 0;
`endif
        reset_dut();
        ang = 4; pw = 8; prev = 4'b0;
        for (int i = 0; i < 100; i++) begin
            key_n = 4'($urandom_range(0, 15));
            idle(3); tick();
            cur = ~key_n;
            for (int k = 0; k < 4; k++) begin
                evt[k] = cur[k] & ~prev[k];
`ifdef AUTO_REPEAT_EN
                if (cur[k] && prev[k]) begin
                    held[k]++;
                    if (held[k] % REP == 0) evt[k] = 1'b1;
                end else begin
                    held[k] = 0;
                end
`endif
            end
            prev = cur;
            if (evt[0] && !evt[1]) ang = (ang < 8) ? ang + 1 : 8;
            else if (evt[1] && !evt[0]) ang = (ang > 0) ? ang - 1 : 0;
            if (evt[2] && !evt[3]) pw = (pw < 15) ? pw + 1 : 15;
            else if (evt[3] && !evt[2]) pw = (pw > 0) ? pw - 1 : 0;
            checks++; if (angle !== 4'(ang)) begin errors++; $display("FAIL rand_angle step %0d got %0d want %0d", i, angle, ang); end
            checks++; if (power !== 4'(pw)) begin errors++; $display("FAIL rand_power step %0d got %0d want %0d", i, power, pw); end
        end
        key_n = 4'hF; idle(3); tick();
    endtask

    task automatic test_fire();
        reset_dut();
        press(0);
        press(2);
        fire = 1'b1; key_n[0] = 1'b0; idle(3); tick();
        checks++; if (launch !== 1'b1) begin errors++; $display("FAIL launch_rise got %0d want 1", launch); end
        checks++; if (phase !== 2'd1) begin errors++; $display("FAIL fire_phase got %0d want 1", phase); end
        checks++; if (arrow_en !== 1'b0) begin errors++; $display("FAIL fire_arrow got %0d want 0", arrow_en); end
        checks++; if (angle !== 4'd5) begin errors++; $display("FAIL fire_angle got %0d want 5", angle); end
        checks++; if (power !== 4'd9) begin errors++; $display("FAIL fire_power got %0d want 9", power); end
        idle(1);
        checks++; if (launch !== 1'b0) begin errors++; $display("FAIL launch_width got %0d want 0", launch); end
        key_n[0] = 1'b1; idle(3); tick();
        press(0);
        press(2);
        checks++; if (angle !== 4'd5) begin errors++; $display("FAIL flight_angle got %0d want 5", angle); end
        checks++; if (power !== 4'd9) begin errors++; $display("FAIL flight_power got %0d want 9", power); end
    endtask

    task automatic test_land_hit();
        int seen;
        land(1'b1);
        checks++; if (phase !== 2'd2) begin errors++; $display("FAIL land_phase got %0d want 2", phase); end
        checks++; if (score !== 8'd1) begin errors++; $display("FAIL land_score got %0d want 1", score); end
        ticks(119);
        checks++; if (phase !== 2'd2) begin errors++; $display("FAIL hold119_phase got %0d want 2", phase); end
        tick();
        checks++; if (phase !== 2'd0) begin errors++; $display("FAIL hold120_phase got %0d want 0", phase); end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (launch === 1'b1 || phase !== 2'd0) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL fire_held_relaunch got %0d want 0", seen); end
        fire_toggle();
        checks++; if (launch !== 1'b1) begin errors++; $display("FAIL relaunch got %0d want 1", launch); end
    endtask

    task automatic test_timeout();
        ticks(599);
        checks++; if (phase !== 2'd1) begin errors++; $display("FAIL to599_phase got %0d want 1", phase); end
        tick();
        checks++; if (phase !== 2'd2) begin errors++; $display("FAIL to600_phase got %0d want 2", phase); end
        checks++; if (score !== 8'd1) begin errors++; $display("FAIL to_score got %0d want 1", score); end
        ticks(120);
        fire_toggle();
        ticks(599);
        update = 1'b1; ball_landed = 1'b1; ball_hit = 1'b1;
        @(negedge VGA_CLK);
        update = 1'b0; ball_landed = 1'b0; ball_hit = 1'b0;
        checks++; if (phase !== 2'd2) begin errors++; $display("FAIL tie_phase got %0d want 2", phase); end
        checks++; if (score !== 8'd2) begin errors++; $display("FAIL tie_score got %0d want 2", score); end
        ticks(120);
    endtask

    task automatic test_saturate();
        int want;
        want = 2;
        while (want < 255) begin
            fire_toggle();
            land(1'b1);
            want++;
            ticks(120);
        end
        checks++; if (score !== 8'd255) begin errors++; $display("FAIL score_255 got %0d want 255", score); end
        fire_toggle();
        land(1'b1);
        checks++; if (score !== 8'd255) begin errors++; $display("FAIL score_sat got %0d want 255", score); end
        ticks(120);
    endtask

    task automatic test_reset_flight();
        fire_toggle();
        checks++; if (phase !== 2'd1) begin errors++; $display("FAIL pre_rst_phase got %0d want 1", phase); end
        rst = 1'b1;
        @(negedge VGA_CLK);
        rst = 1'b0;
        checks++; if (phase !== 2'd0) begin errors++; $display("FAIL rst_phase got %0d want 0", phase); end
        checks++; if (angle !== 4'd4) begin errors++; $display("FAIL rst_angle got %0d want 4", angle); end
        checks++; if (power !== 4'd8) begin errors++; $display("FAIL rst_power got %0d want 8", power); end
        checks++; if (score !== 8'd0) begin errors++; $display("FAIL rst_score got %0d want 0", score); end
        checks++; if (launch !== 1'b0) begin errors++; $display("FAIL rst_launch got %0d want 0", launch); end
        fire = 1'b0; idle(3); tick();
        fire = 1'b1; idle(3);
        rst = 1'b1; update = 1'b1;
        @(negedge VGA_CLK);
        rst = 1'b0; update = 1'b0;
        checks++; if (launch !== 1'b0) begin errors++; $display("FAIL rst_drop_launch got %0d want 0", launch); end
        checks++; if (phase !== 2'd0) begin errors++; $display("FAIL rst_drop_phase got %0d want 0", phase); end
        fire = 1'b0;
    endtask

    initial begin
        test_reset();
        test_steps();
        test_same_tick();
        test_random_aim();
        test_fire();
        test_land_hit();
        test_timeout();
        test_saturate();
        test_reset_flight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
